// File: rtl/dmem_run_ctrl_pkg.sv
// Shared definitions for the data-memory / run controller.
package dmem_run_ctrl_pkg;

  // Run-controller states: host owns RAM in IDLE, core owns it in RUN.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // MEMCtrl encoding from the core: 1 = write Ddout to DAddress, 0 = read only.
  localparam logic MEMCTRL_WR = 1'b1;
  localparam logic MEMCTRL_RD = 1'b0;

endpackage

// File: rtl/dmem_sp_ram.sv
// Single-port synchronous RAM, read-first, no reset on storage.
module dmem_sp_ram #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Write commits at the edge; the read returns the pre-write contents.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_run_ctrl.sv
// Data RAM owner and host/core arbiter with run FSM and run-cycle counter.
module dmem_run_ctrl
  import dmem_run_ctrl_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             MEMCtrl,
  input  logic [AW-1:0]    DAddress,
  input  logic [DW-1:0]    Ddout,
  output logic [DW-1:0]    Ddin,
  input  logic             h_valid,
  input  logic             h_we,
  input  logic [AW-1:0]    h_addr,
  input  logic [DW-1:0]    h_wdata,
  output logic             h_ready,
  output logic             h_rvalid,
  output logic [DW-1:0]    h_rdata,
  input  logic             start,
  input  logic             done,
  output logic             proc_run,
  output logic [CNT_W-1:0] run_cycles
);

  state_t        state, state_nxt;
  logic          host_rd;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_q;
  logic          core_rd_q;
  logic          host_rd_q;
  logic [DW-1:0] ddin_hold;
  logic [DW-1:0] rdata_hold;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus state-decoded handshake outputs.
  always_comb begin
    state_nxt = state;
    h_ready   = 1'b0;
    proc_run  = 1'b0;
    case (state)
      ST_IDLE: begin
        h_ready = 1'b1;
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        proc_run = 1'b1;
        if (done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Port mux: the owning side drives address, data and write enable.
  always_comb begin
    host_rd   = h_valid && h_ready && !h_we;
    ram_we    = 1'b0;
    ram_addr  = h_addr;
    ram_wdata = h_wdata;
    if (state == ST_RUN) begin
      ram_addr  = DAddress;
      ram_wdata = Ddout;
      ram_we    = (MEMCtrl == MEMCTRL_WR) && !RST;
    end else begin
      ram_we    = h_valid && h_we && !RST;
    end
  end

  dmem_sp_ram #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  // Run-cycle counter: cleared on start, saturating count of RUN cycles.
  always_ff @(posedge CLK) begin
    if (RST) begin
      run_cycles <= '0;
    end else if (state == ST_IDLE) begin
      if (start) run_cycles <= '0;
    end else if (run_cycles != '1) begin
      run_cycles <= run_cycles + CNT_W'(1);
    end
  end

  // Track which port the RAM output belongs to and hold each side's last value.
  always_ff @(posedge CLK) begin
    if (RST) begin
      core_rd_q  <= 1'b0;
      host_rd_q  <= 1'b0;
      ddin_hold  <= '0;
      rdata_hold <= '0;
    end else begin
      core_rd_q  <= (state == ST_RUN);
      host_rd_q  <= host_rd;
      ddin_hold  <= Ddin;
      rdata_hold <= h_rdata;
    end
  end

  // The shared RAM output register feeds both ports; each port shows it only
  // on the cycle after its own read and otherwise replays its held value.
  assign Ddin     = core_rd_q ? ram_q : ddin_hold;
  assign h_rdata  = host_rd_q ? ram_q : rdata_hold;
  assign h_rvalid = host_rd_q;

endmodule

// File: tb/tb_dmem_run_ctrl.sv
// Self-checking bench for dmem_run_ctrl with a host-read scoreboard.
module tb_dmem_run_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memctrl = 1'b0;
  logic [7:0] daddr = '0;
  logic [7:0] ddout = '0;
  logic       h_valid = 1'b0;
  logic       h_we = 1'b0;
  logic [7:0] h_addr = '0;
  logic [7:0] h_wdata = '0;
  logic       start = 1'b0;
  logic       done = 1'b0;

  logic [7:0]  ddin, h_rdata;
  logic        h_ready, h_rvalid, proc_run;
  logic [15:0] run_cycles;

  logic [7:0] ddin_s, h_rdata_s;
  logic       h_ready_s, h_rvalid_s, proc_run_s;
  logic [3:0] run_cycles_s;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [256];
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  dmem_run_ctrl #(.AW(8), .DW(8), .CNT_W(16)) dut (
    .CLK(clk), .RST(rst), .MEMCtrl(memctrl), .DAddress(daddr), .Ddout(ddout),
    .Ddin(ddin), .h_valid(h_valid), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_ready(h_ready), .h_rvalid(h_rvalid),
    .h_rdata(h_rdata), .start(start), .done(done), .proc_run(proc_run),
    .run_cycles(run_cycles)
  );

  dmem_run_ctrl #(.AW(8), .DW(8), .CNT_W(4)) dut_sat (
    .CLK(clk), .RST(rst), .MEMCtrl(memctrl), .DAddress(daddr), .Ddout(ddout),
    .Ddin(ddin_s), .h_valid(h_valid), .h_we(h_we), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_ready(h_ready_s), .h_rvalid(h_rvalid_s),
    .h_rdata(h_rdata_s), .start(start), .done(done), .proc_run(proc_run_s),
    .run_cycles(run_cycles_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Host write in IDLE, one cycle; updates the reference memory.
  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    h_valid = 1'b1; h_we = 1'b1; h_addr = a; h_wdata = d;
    tick();
    mdl[a] = d;
    h_valid = 1'b0; h_we = 1'b0;
  endtask

  // Host read in IDLE; expected data goes to the scoreboard at acceptance.
  task automatic host_read(input logic [7:0] a);
    h_valid = 1'b1; h_we = 1'b0; h_addr = a;
    exp_q.push_back(mdl[a]);
    tick();
    h_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++; if (ddin !== 8'h00) begin errors++; $display("FAIL reset_ddin got %h want 00", ddin); end
    checks++; if (h_rdata !== 8'h00) begin errors++; $display("FAIL reset_h_rdata got %h want 00", h_rdata); end
    checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL reset_h_rvalid got %b want 0", h_rvalid); end
    checks++; if (proc_run !== 1'b0) begin errors++; $display("FAIL reset_proc_run got %b want 0", proc_run); end
    checks++; if (run_cycles !== 16'd0) begin errors++; $display("FAIL reset_run_cycles got %0d want 0", run_cycles); end
    checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL reset_h_ready got %b want 1", h_ready); end
  endtask

  task automatic test_host_rw();
    host_write(8'h10, 8'h3C);
    host_read(8'h10);
    checks++; if (h_rvalid !== 1'b1) begin errors++; $display("FAIL hostrw_rvalid got %b want 1", h_rvalid); end
    exp_v = exp_q.pop_front();
    checks++; if (h_rdata !== exp_v) begin errors++; $display("FAIL hostrw_rdata got %h want %h", h_rdata, exp_v); end
    tick();
    checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL hostrw_rvalid_pulse got %b want 0", h_rvalid); end
    checks++; if (h_rdata !== 8'h3C) begin errors++; $display("FAIL hostrw_rdata_hold got %h want 3c", h_rdata); end
  endtask

  task automatic test_run_handoff();
    host_write(8'h20, 8'h05);
    host_write(8'h21, 8'h99);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (proc_run !== 1'b1) begin errors++; $display("FAIL run_start_proc_run got %b want 1", proc_run); end
    checks++; if (h_ready !== 1'b0) begin errors++; $display("FAIL run_start_h_ready got %b want 0", h_ready); end
    checks++; if (run_cycles !== 16'd0) begin errors++; $display("FAIL run_start_cycles got %0d want 0", run_cycles); end
    for (int unsigned i = 1; i <= 12; i++) begin
      daddr   = (i == 1) ? 8'h20 : 8'h21;
      memctrl = (i == 2);
      ddout   = 8'h0A;
      done    = (i == 12);
      tick();
      if (i == 1) begin
        checks++; if (ddin !== 8'h05) begin errors++; $display("FAIL run_core_read got %h want 05", ddin); end
        checks++; if (run_cycles !== 16'd1) begin errors++; $display("FAIL run_first_count got %0d want 1", run_cycles); end
      end
      if (i == 2) begin
        checks++; if (ddin !== mdl[8'h21]) begin errors++; $display("FAIL run_read_first got %h want %h", ddin, mdl[8'h21]); end
        mdl[8'h21] = 8'h0A;
      end
      if (i == 3) begin
        checks++; if (ddin !== 8'h0A) begin errors++; $display("FAIL run_write_visible got %h want 0a", ddin); end
      end
      if (i < 12) begin
        checks++; if (proc_run !== 1'b1) begin errors++; $display("FAIL run_proc_run_%0d got %b want 1", i, proc_run); end
      end
    end
    memctrl = 1'b0;
    done = 1'b0;
    checks++; if (proc_run !== 1'b0) begin errors++; $display("FAIL run_done_proc_run got %b want 0", proc_run); end
    checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL run_done_h_ready got %b want 1", h_ready); end
    checks++; if (run_cycles !== 16'd12) begin errors++; $display("FAIL run_cycles got %0d want 12", run_cycles); end
    daddr = 8'h20;
    tick();
    checks++; if (run_cycles !== 16'd12) begin errors++; $display("FAIL run_cycles_frozen got %0d want 12", run_cycles); end
    checks++; if (ddin !== 8'h0A) begin errors++; $display("FAIL run_ddin_hold got %h want 0a", ddin); end
    host_read(8'h21);
    checks++; if (h_rvalid !== 1'b1) begin errors++; $display("FAIL run_readback_rvalid got %b want 1", h_rvalid); end
    exp_v = exp_q.pop_front();
    checks++; if (h_rdata !== exp_v) begin errors++; $display("FAIL run_readback got %h want %h", h_rdata, exp_v); end
  endtask

  task automatic test_host_blocked();
    start = 1'b1;
    tick();
    start = 1'b0;
    h_valid = 1'b1; h_we = 1'b0; h_addr = 8'h21;
    for (int unsigned i = 1; i <= 5; i++) begin
      done = (i == 5);
      tick();
      if (i < 5) begin
        checks++; if (h_ready !== 1'b0) begin errors++; $display("FAIL blocked_h_ready_%0d got %b want 0", i, h_ready); end
      end
      checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL blocked_h_rvalid_%0d got %b want 0", i, h_rvalid); end
    end
    done = 1'b0;
    checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL blocked_release_h_ready got %b want 1", h_ready); end
    exp_q.push_back(mdl[8'h21]);
    tick();
    h_valid = 1'b0;
    checks++; if (h_rvalid !== 1'b1) begin errors++; $display("FAIL blocked_accept_rvalid got %b want 1", h_rvalid); end
    exp_v = exp_q.pop_front();
    checks++; if (h_rdata !== exp_v) begin errors++; $display("FAIL blocked_rdata got %h want %h", h_rdata, exp_v); end
    tick();
    checks++; if (h_rvalid !== 1'b0) begin errors++; $display("FAIL blocked_rvalid_pulse got %b want 0", h_rvalid); end
  endtask

  task automatic test_ignored_writes();
    host_write(8'h30, 8'h5A);
    memctrl = 1'b1; daddr = 8'h30; ddout = 8'hFF;
    tick();
    memctrl = 1'b0;
    host_read(8'h30);
    checks++; if (h_rvalid !== 1'b1) begin errors++; $display("FAIL ignored_rvalid got %b want 1", h_rvalid); end
    exp_v = exp_q.pop_front();
    checks++; if (h_rdata !== exp_v) begin errors++; $display("FAIL ignored_write got %h want %h", h_rdata, exp_v); end
  endtask

  task automatic test_simultaneous();
    start = 1'b1; h_valid = 1'b1; h_we = 1'b1; h_addr = 8'h40; h_wdata = 8'h77;
    tick();
    mdl[8'h40] = 8'h77;
    start = 1'b0; h_valid = 1'b0; h_we = 1'b0;
    checks++; if (proc_run !== 1'b1) begin errors++; $display("FAIL simul_start_write_run got %b want 1", proc_run); end
    done = 1'b1;
    tick();
    done = 1'b0;
    host_read(8'h40);
    checks++; if (h_rvalid !== 1'b1) begin errors++; $display("FAIL simul_rvalid got %b want 1", h_rvalid); end
    exp_v = exp_q.pop_front();
    checks++; if (h_rdata !== exp_v) begin errors++; $display("FAIL simul_write_landed got %h want %h", h_rdata, exp_v); end
    start = 1'b1; done = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (proc_run !== 1'b1) begin errors++; $display("FAIL simul_start_done_run got %b want 1", proc_run); end
    tick();
    done = 1'b0;
    checks++; if (proc_run !== 1'b0) begin errors++; $display("FAIL simul_done_idle got %b want 0", proc_run); end
  endtask

  task automatic test_reset_midrun();
    host_write(8'h50, 8'hC3);
    start = 1'b1;
    tick();
    start = 1'b0;
    daddr = 8'h50;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (proc_run !== 1'b0) begin errors++; $display("FAIL rstrun_proc_run got %b want 0", proc_run); end
    checks++; if (run_cycles !== 16'd0) begin errors++; $display("FAIL rstrun_cycles got %0d want 0", run_cycles); end
    checks++; if (ddin !== 8'h00) begin errors++; $display("FAIL rstrun_ddin got %h want 00", ddin); end
    checks++; if (h_rdata !== 8'h00) begin errors++; $display("FAIL rstrun_h_rdata got %h want 00", h_rdata); end
    checks++; if (h_ready !== 1'b1) begin errors++; $display("FAIL rstrun_h_ready got %b want 1", h_ready); end
    host_read(8'h50);
    checks++; if (h_rvalid !== 1'b1) begin errors++; $display("FAIL rstrun_rvalid got %b want 1", h_rvalid); end
    exp_v = exp_q.pop_front();
    checks++; if (h_rdata !== exp_v) begin errors++; $display("FAIL rstrun_ram_kept got %h want %h", h_rdata, exp_v); end
  endtask

  task automatic test_saturation();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned i = 1; i <= 20; i++) begin
      done = (i == 20);
      tick();
    end
    done = 1'b0;
    checks++; if (run_cycles !== 16'd20) begin errors++; $display("FAIL sat_wide_count got %0d want 20", run_cycles); end
    checks++; if (run_cycles_s !== 4'hF) begin errors++; $display("FAIL sat_narrow_count got %h want f", run_cycles_s); end
    checks++; if (proc_run_s !== 1'b0) begin errors++; $display("FAIL sat_narrow_idle got %b want 0", proc_run_s); end
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_run_handoff();
    test_host_blocked();
    test_ignored_writes();
    test_simultaneous();
    test_reset_midrun();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
